// File: rtl/pkt_merge_arb.sv
`timescale 1ns/1ps
// pkt_merge_arb: merges two packet sources, each with a per-packet metadata word,
// onto one output. Round-robin arbitration is packet-granular; the metadata word precedes each packet.
module pkt_merge_arb #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6,
  parameter int unsigned META_W  = 512
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic [DATA_W-1:0]  s0_pkt_data,
  input  logic               s0_pkt_sop,
  input  logic               s0_pkt_eop,
  input  logic [EMPTY_W-1:0] s0_pkt_empty,
  input  logic               s0_pkt_valid,
  output logic               s0_pkt_ready,
  input  logic [META_W-1:0]  s0_meta_data,
  input  logic               s0_meta_valid,
  output logic               s0_meta_ready,

  input  logic [DATA_W-1:0]  s1_pkt_data,
  input  logic               s1_pkt_sop,
  input  logic               s1_pkt_eop,
  input  logic [EMPTY_W-1:0] s1_pkt_empty,
  input  logic               s1_pkt_valid,
  output logic               s1_pkt_ready,
  input  logic [META_W-1:0]  s1_meta_data,
  input  logic               s1_meta_valid,
  output logic               s1_meta_ready,

  output logic [DATA_W-1:0]  out_pkt_data,
  output logic               out_pkt_sop,
  output logic               out_pkt_eop,
  output logic [EMPTY_W-1:0] out_pkt_empty,
  output logic               out_pkt_valid,
  input  logic               out_pkt_ready,
  output logic [META_W-1:0]  out_meta_data,
  output logic               out_meta_valid,
  input  logic               out_meta_ready,

  input  logic               out_pkt_almost_full,
  input  logic               out_meta_almost_full,

  output logic [31:0]        cnt_s0,
  output logic [31:0]        cnt_s1,
  output logic               grant_src
);

  typedef enum logic [1:0] {
    IDLE,
    META,
    PKT
  } state_t;

  state_t state;
  logic   last_grant;
  logic   elig0;
  logic   elig1;
  logic   can_grant;
  logic   pick;
  logic   in_meta;
  logic   in_pkt;
  logic   meta_xfer;
  logic   pkt_last_xfer;

  always_comb begin
    elig0     = s0_meta_valid & s0_pkt_valid & s0_pkt_sop;
    elig1     = s1_meta_valid & s1_pkt_valid & s1_pkt_sop;
    can_grant = (elig0 | elig1) & ~out_pkt_almost_full & ~out_meta_almost_full;
    // On a tie the source not served last wins; otherwise the only eligible one.
    pick      = (elig0 & elig1) ? ~last_grant : elig1;
  end

  always_comb begin
    in_meta = (state == META);
    in_pkt  = (state == PKT);

    out_meta_data  = s0_meta_data;
    out_pkt_data   = s0_pkt_data;
    out_pkt_sop    = s0_pkt_sop;
    out_pkt_eop    = s0_pkt_eop;
    out_pkt_empty  = s0_pkt_empty;
    out_meta_valid = in_meta & s0_meta_valid;
    out_pkt_valid  = in_pkt & s0_pkt_valid;
    if (grant_src) begin
      out_meta_data  = s1_meta_data;
      out_pkt_data   = s1_pkt_data;
      out_pkt_sop    = s1_pkt_sop;
      out_pkt_eop    = s1_pkt_eop;
      out_pkt_empty  = s1_pkt_empty;
      out_meta_valid = in_meta & s1_meta_valid;
      out_pkt_valid  = in_pkt & s1_pkt_valid;
    end

    s0_meta_ready = in_meta & ~grant_src & out_meta_ready;
    s1_meta_ready = in_meta &  grant_src & out_meta_ready;
    s0_pkt_ready  = in_pkt  & ~grant_src & out_pkt_ready;
    s1_pkt_ready  = in_pkt  &  grant_src & out_pkt_ready;

    meta_xfer     = out_meta_valid & out_meta_ready;
    pkt_last_xfer = out_pkt_valid & out_pkt_ready & out_pkt_eop;
  end

  // Almost-full only gates new grants; an owned packet always runs to its eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_src  <= 1'b0;
      cnt_s0     <= '0;
      cnt_s1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_grant) begin
            grant_src  <= pick;
            last_grant <= pick;
            state      <= META;
          end
        end
        META: begin
          if (meta_xfer) state <= PKT;
        end
        PKT: begin
          if (pkt_last_xfer) begin
            state <= IDLE;
            if (grant_src) cnt_s1 <= cnt_s1 + 32'd1;
            else           cnt_s0 <= cnt_s0 + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_merge_arb.sv
`timescale 1ns/1ps
// Bench for pkt_merge_arb: directed literal scenarios plus random traffic,
// every cycle compared against a transaction-level model of the merge rules.
module tb_pkt_merge_arb;
  localparam int unsigned DW = 64;
  localparam int unsigned EW = 6;
  localparam int unsigned MW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] sd   [2];
  logic          ssop [2];
  logic          seop [2];
  logic [EW-1:0] sem  [2];
  logic          spv  [2];
  logic [MW-1:0] md   [2];
  logic          smv  [2];
  logic          spr  [2];
  logic          smr  [2];

  logic          out_pkt_ready, out_meta_ready, out_pkt_almost_full, out_meta_almost_full;
  logic [DW-1:0] out_pkt_data;
  logic          out_pkt_sop, out_pkt_eop, out_pkt_valid;
  logic [EW-1:0] out_pkt_empty;
  logic [MW-1:0] out_meta_data;
  logic          out_meta_valid;
  logic [31:0]   cnt_s0, cnt_s1;
  logic          grant_src;

  pkt_merge_arb #(.DATA_W(DW), .EMPTY_W(EW), .META_W(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_pkt_data(sd[0]), .s0_pkt_sop(ssop[0]), .s0_pkt_eop(seop[0]), .s0_pkt_empty(sem[0]),
    .s0_pkt_valid(spv[0]), .s0_pkt_ready(spr[0]),
    .s0_meta_data(md[0]), .s0_meta_valid(smv[0]), .s0_meta_ready(smr[0]),
    .s1_pkt_data(sd[1]), .s1_pkt_sop(ssop[1]), .s1_pkt_eop(seop[1]), .s1_pkt_empty(sem[1]),
    .s1_pkt_valid(spv[1]), .s1_pkt_ready(spr[1]),
    .s1_meta_data(md[1]), .s1_meta_valid(smv[1]), .s1_meta_ready(smr[1]),
    .out_pkt_data(out_pkt_data), .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop),
    .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid), .out_pkt_ready(out_pkt_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .out_pkt_almost_full(out_pkt_almost_full), .out_meta_almost_full(out_meta_almost_full),
    .cnt_s0(cnt_s0), .cnt_s1(cnt_s1), .grant_src(grant_src)
  );

  int unsigned tests;
  int unsigned fails;

  // stimulus knobs and per-source driver state
  logic        c_en [2];
  int unsigned c_len, c_pv, c_prdy, c_afp, c_afm;
  int unsigned d_len [2], d_beat [2], d_id [2];
  int          d_npk [2];
  logic        d_mdone [2];
  logic        x_meta [2], x_pkt [2];

  // model state
  logic        own_v, own_s, msent, prefer, preload1;
  logic [31:0] mcnt [2];
  int unsigned bidx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pct(input int unsigned p);
    return $urandom_range(99, 0) < p;
  endfunction

  function automatic int unsigned new_len();
    return (c_len != 0) ? c_len : $urandom_range(4, 1);
  endfunction

  task automatic drive_src(input logic si);
    logic act;
    if (!rst_n) begin
      if (d_mdone[si] || d_beat[si] != 0) d_id[si]++;
      d_beat[si]  = 0;
      d_mdone[si] = 1'b0;
      d_len[si]   = new_len();
    end else begin
      if (x_meta[si]) d_mdone[si] = 1'b1;
      if (x_pkt[si]) begin
        if (d_beat[si] + 1 == d_len[si]) begin
          d_beat[si]  = 0;
          d_mdone[si] = 1'b0;
          d_id[si]++;
          d_npk[si]--;
          d_len[si]   = new_len();
        end else begin
          d_beat[si]++;
        end
      end
    end
    act      = c_en[si] && (d_npk[si] > 0);
    smv[si]  = act && !d_mdone[si] && pct(c_pv);
    spv[si]  = act && pct(c_pv);
    ssop[si] = (d_beat[si] == 0);
    seop[si] = (d_beat[si] + 1 == d_len[si]);
    sd[si]   = {8'(si), 24'(d_id[si]), 16'(d_beat[si]), 16'hC3A5};
    md[si]   = {8'(si), 24'(d_id[si])};
    sem[si]  = EW'(d_id[si] + d_beat[si]);
  endtask

  task automatic drive_step();
    drive_src(1'b0);
    drive_src(1'b1);
    out_pkt_ready        = pct(c_prdy);
    out_meta_ready       = pct(c_prdy);
    out_pkt_almost_full  = pct(c_afp);
    out_meta_almost_full = pct(c_afm);
  endtask

  // Model: one owner at a time; meta word first, then beats until eop; idle between packets.
  task automatic model_step();
    logic       emv, epv;
    logic [1:0] emr, epr, el;
    if (preload1) mcnt[1] = '1;
    x_meta[0] = smv[0] & smr[0];
    x_meta[1] = smv[1] & smr[1];
    x_pkt[0]  = spv[0] & spr[0];
    x_pkt[1]  = spv[1] & spr[1];
    if (!rst_n) begin
      own_v = 1'b0; prefer = 1'b0; msent = 1'b0; bidx = 0;
      mcnt[0] = '0; mcnt[1] = '0;
      chk("rst_valids", 64'({out_pkt_valid, out_meta_valid}), 64'(0));
      chk("rst_readys", 64'({smr[1], smr[0], spr[1], spr[0]}), 64'(0));
      chk("rst_cnt", {cnt_s1, cnt_s0}, 64'(0));
      chk("rst_grant_src", 64'(grant_src), 64'(0));
      return;
    end
    emv = 1'b0; epv = 1'b0; emr = '0; epr = '0;
    if (own_v && !msent) begin
      emv = smv[own_s];
      emr[own_s] = out_meta_ready;
    end
    if (own_v && msent) begin
      epv = spv[own_s];
      epr[own_s] = out_pkt_ready;
    end
    chk("meta_valid", 64'(out_meta_valid), 64'(emv));
    chk("pkt_valid", 64'(out_pkt_valid), 64'(epv));
    chk("readys", 64'({smr[1], smr[0], spr[1], spr[0]}), 64'({emr, epr}));
    chk("cnt", {cnt_s1, cnt_s0}, {mcnt[1], mcnt[0]});
    if (own_v) chk("grant_src", 64'(grant_src), 64'(own_s));
    if (emv) chk("meta_data", 64'(out_meta_data), 64'(md[own_s]));
    if (epv) begin
      chk("pkt_data", out_pkt_data, sd[own_s]);
      chk("pkt_ctl", 64'({out_pkt_sop, out_pkt_eop, out_pkt_empty}),
          64'({ssop[own_s], seop[own_s], sem[own_s]}));
    end
    if (!own_v) begin
      el = {smv[1] & spv[1] & ssop[1], smv[0] & spv[0] & ssop[0]};
      if (el != 2'b00 && !out_pkt_almost_full && !out_meta_almost_full) begin
        own_s  = (el == 2'b11) ? prefer : el[1];
        own_v  = 1'b1;
        prefer = ~own_s;
        msent  = 1'b0;
        bidx   = 0;
      end
    end else if (!msent) begin
      if (emv && out_meta_ready) msent = 1'b1;
    end else if (epv && out_pkt_ready) begin
      chk("beat_order", 64'(out_pkt_data[31:16]), 64'(bidx));
      bidx++;
      if (seop[own_s]) begin
        mcnt[own_s] = mcnt[own_s] + 32'd1;
        own_v = 1'b0;
      end
    end
  endtask

  task automatic start_test(input logic e0, input logic e1, input int n0, input int n1,
                            input int unsigned len, input int unsigned pv, input int unsigned prdy,
                            input int unsigned afp, input int unsigned afm);
    rst_n = 1'b0;
    c_en[0] = e0; c_en[1] = e1; d_npk[0] = n0; d_npk[1] = n1;
    c_len = len; c_pv = pv; c_prdy = prdy; c_afp = afp; c_afm = afm;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cnt(input int unsigned w0, input int unsigned w1,
                          input int unsigned maxc, input string nm);
    for (int unsigned c = 0; c < maxc; c++) begin
      if (cnt_s0 == w0 && cnt_s1 == w1) break;
      @(negedge clk);
      #1;
    end
    chk(nm, {cnt_s1, cnt_s0}, {w1, w0});
  endtask

  initial begin
    logic [2:0] exp1 [6];
    logic [3:0] ord;
    int unsigned n, nb;

    tests = 0; fails = 0;
    preload1 = 1'b0;
    own_v = 1'b0; own_s = 1'b0; msent = 1'b0; prefer = 1'b0; bidx = 0;
    out_pkt_ready = 1'b0; out_meta_ready = 1'b0;
    out_pkt_almost_full = 1'b0; out_meta_almost_full = 1'b0;
    c_len = 1; c_pv = 0; c_prdy = 0; c_afp = 0; c_afm = 0;
    for (int i = 0; i < 2; i++) begin
      c_en[i] = 1'b0; d_len[i] = 1; d_beat[i] = 0; d_id[i] = 0; d_npk[i] = 0;
      d_mdone[i] = 1'b0; x_meta[i] = 1'b0; x_pkt[i] = 1'b0; mcnt[i] = '0;
      sd[i] = '0; ssop[i] = 1'b0; seop[i] = 1'b0; sem[i] = '0; spv[i] = 1'b0;
      md[i] = '0; smv[i] = 1'b0;
    end

    fork
      forever begin
        @(posedge clk);
        #1;
        drive_step();
      end
      forever begin
        @(negedge clk);
        #2;
        model_step();
      end
      begin
        #2_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join_none

    // Lone s0, 3 beats, always ready: grant, meta, three beats, idle.
    exp1 = '{3'b000, 3'b100, 3'b010, 3'b010, 3'b011, 3'b000};
    start_test(1'b1, 1'b0, 1, 0, 3, 100, 100, 0, 0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("single_seq", 64'({out_meta_valid, out_pkt_valid, out_pkt_eop & out_pkt_valid}), 64'(exp1[c]));
    end
    chk("single_cnt", {cnt_s1, cnt_s0}, 64'(1));

    // Both eligible, single-beat packets: strict alternation from s0.
    start_test(1'b1, 1'b1, 2, 2, 1, 100, 100, 0, 0);
    n = 0; ord = '0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (out_pkt_valid && out_pkt_ready) begin
        ord = {grant_src, ord[3:1]};
        n++;
      end
      @(negedge clk);
    end
    chk("rr_count", 64'(n), 64'(4));
    chk("rr_order", 64'(ord), 64'(4'b1010));
    wait_cnt(2, 2, 10, "rr_cnt");

    // Almost-full holds off any grant; grant follows one cycle after release.
    start_test(1'b1, 1'b1, 1, 1, 2, 100, 100, 100, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("af_hold", 64'({out_meta_valid, out_pkt_valid, smr[1], smr[0], spr[1], spr[0]}), 64'(0));
      @(negedge clk);
    end
    #1;
    c_afp = 0;
    @(negedge clk);
    #1;
    chk("af_grant_cycle", 64'(out_meta_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("af_meta_after", 64'({out_meta_valid, grant_src}), 64'(2'b10));
    wait_cnt(1, 1, 40, "af_cnt");

    // Reset during beat 2 of 4: outputs drop at once, packet abandoned, next one intact.
    start_test(1'b1, 1'b0, 1, 0, 4, 100, 100, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_beat", 64'({out_pkt_valid, out_pkt_data[31:16]}), 64'({1'b1, 16'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 64'({out_pkt_valid, out_meta_valid, spr[0], smr[0]}), 64'(0));
    chk("async_rst_cnt", {cnt_s1, cnt_s0}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (out_pkt_valid && out_pkt_ready) nb++;
      if (cnt_s0 == 32'd1) break;
      @(negedge clk);
    end
    chk("post_rst_beats", 64'(nb), 64'(4));
    chk("post_rst_cnt", {cnt_s1, cnt_s0}, 64'(1));

    // Counter wrap: preload cnt_s1 to all-ones, one more s1 packet wraps to 0.
    start_test(1'b0, 1'b0, 0, 0, 2, 100, 100, 0, 0);
    #1;
    preload1 = 1'b1;
    force dut.cnt_s1 = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    release dut.cnt_s1;
    preload1 = 1'b0;
    chk("cnt_preload", 64'(cnt_s1), 64'(32'hFFFF_FFFF));
    c_en[1] = 1'b1;
    d_npk[1] = 1;
    wait_cnt(0, 0, 30, "cnt_wrap");

    // Random traffic with backpressure, almost-full and a mid-run reset.
    start_test(1'b1, 1'b1, 100000, 100000, 0, 70, 75, 15, 15);
    repeat (1500) @(negedge clk);
    #3;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_merge_arb.md
PKT_MERGE_ARB -- requirements
Module: pkt_merge_arb

Interface
REQ-001 Parameter: DATA_W, 512, packet data width.
REQ-002 Parameter: EMPTY_W, 6, packet empty-field width.
REQ-003 Parameter: META_W, 512, metadata word width.
REQ-004 Clk  input  1  the single clock; all logic on rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s0_pkt_data/sop/eop/empty/valid  input  DATA_W/1/1/EMPTY_W/1  source 0 (main path) packet stream; s0_pkt_ready output 1.
REQ-007 s0_meta_data/valid  input  META_W/1  source 0 per-packet metadata; s0_meta_ready output 1.
REQ-008 s1_pkt_* and s1_meta_*  same as REQ-006/007  source 1 (bypass path).
REQ-009 out_pkt_data/sop/eop/empty/valid  output  DATA_W/1/1/EMPTY_W/1  merged packet stream; out_pkt_ready input 1.
REQ-010 out_meta_data/valid  output  META_W/1  merged metadata; out_meta_ready input 1.
REQ-011 out_pkt_almost_full, out_meta_almost_full  input  1 each  downstream backpressure hints.
REQ-012 cnt_s0, cnt_s1  output  32 each  packets forwarded per source.
REQ-013 grant_src  output  1  source owning output (valid when not IDLE).

Function
REQ-014 Transfer on any stream = valid & ready in same cycle.
REQ-015 FSM states: IDLE, META, PKT.
REQ-016 Source i eligible = si_meta_valid & si_pkt_valid & si_pkt_sop.
REQ-017 IDLE: grant taken only if some source eligible and both almost_full low; else stay IDLE.
REQ-018 Arbitration round-robin, packet-granular: priority to the source not granted last; last_grant resets to 1 (so s0 wins first tie).
REQ-019 Grant registered: IDLE -> META next cycle, grant_src latched; no output valid in the grant cycle.
REQ-020 META: out_meta_* = granted si_meta_*; si_meta_ready = out_meta_ready; other source's readys 0; on meta transfer -> PKT.
REQ-021 PKT: out_pkt_* = granted si_pkt_* (combinational pass-through); si_pkt_ready = out_pkt_ready; on transfer with eop -> IDLE, increment cnt_si.
REQ-022 Almost_full ignored once granted; in-flight packet always completes.
REQ-023 Single-beat packet (sop & eop): PKT lasts until that beat transfers, then IDLE.
REQ-024 Non-granted source: all readys 0 in every state.
REQ-025 IDLE: out_pkt_valid = out_meta_valid = 0, all s*_ready = 0.
REQ-026 Counters wrap 0xFFFFFFFF -> 0, no saturation.
REQ-027 Minimum packet spacing: one IDLE cycle between eop transfer and next meta valid.
REQ-028 Eligibility sampled only in IDLE; source deasserting valid after grant stalls output (valid follows source), no abort.

Reset
REQ-029 On Rst_n low, immediately: state IDLE, last_grant 1, grant_src 0, cnt_s0 = cnt_s1 = 0, all valids/readys 0.
REQ-030 Reset mid-packet abandons the packet; no counter update; after release first grant follows REQ-018.
REQ-031 Reset release synchronous to Clk; first grant possible at first edge after release.

Verification
REQ-032 Only s0 eligible, 3-beat packet, ready=1 -> grant cycle, meta at cycle 1, beats cycles 2-4, cnt_s0=1, IDLE at cycle 5.
REQ-033 Both eligible continuously, 1-beat packets -> output order s0,s1,s0,s1; cnt_s0=cnt_s1=2 after 4 packets.
REQ-034 out_pkt_almost_full=1 while both eligible -> no grant, all readys 0; deassert -> grant within 1 cycle.
REQ-035 almost_full asserted mid-packet, out_pkt_ready toggling 1/0 -> packet completes beat-for-beat, no beats lost or duplicated.
REQ-036 Rst_n low during beat 2 of 4 -> outputs invalid immediately, counters 0, next packet forwarded intact.
REQ-037 cnt_s1 preloaded via 2^32 packets (or force) at 0xFFFFFFFF, one more s1 packet -> cnt_s1=0.
